// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI transmitter.
//   - Status nibble constants for channel voice messages.
//   - msg_len: bytes on the wire for a status nibble (0 = invalid, dropped).
//   - msg_byte: byte sent in a given FSM state; data bytes are forced to 7 bits.
//   - midi_state_e: message FSM state encoding.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    typedef enum logic [1:0] {
        StIdle,
        StSendStatus,
        StSendD1,
        StSendD2
    } midi_state_e;

    function automatic logic [1:0] msg_len(input logic [3:0] status);
        case (status)
            NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: msg_len = 2'd3;
            PROG, CHAN_AT:                         msg_len = 2'd2;
            default:                               msg_len = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(input midi_state_e st, input logic [23:0] m);
        case (st)
            StSendStatus: msg_byte = m[23:16];
            StSendD1:     msg_byte = m[15:8] & 8'h7F;
            StSendD2:     msg_byte = m[7:0] & 8'h7F;
            default:      msg_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per start.
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset (tx forced high)
//   start   in  load data; honoured when idle or during the final stop-bit clock
//   data    in  byte to send, LSB first
//   tx      out serial line, idle high (registered)
//   busy    out frame in progress
//   done    out high during the last clock of the stop bit (combinational)
// Accepting start during the last stop clock gives back-to-back frames with no idle bit.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CntW-1:0] baud_q;
    logic [3:0]      bit_q;
    logic [8:0]      shift_q;   // remaining data bits followed by the stop bit
    logic            busy_q;
    logic            tx_q;
    logic            bit_end;

    assign bit_end = (baud_q == CntW'(CLKS_PER_BIT - 1));
    assign done    = busy_q && bit_end && (bit_q == 4'd9);
    assign tx      = tx_q;
    assign busy    = busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= '1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (start && (!busy_q || done)) begin
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= {1'b1, data};
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
        end else if (busy_q) begin
            if (bit_end) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_q <= baud_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_transmitter.sv
// midi_transmitter: serial MIDI output. Takes 24-bit parsed messages
// ({status, channel, data1, data2}) and sends them as 8N1 frames.
//   clock       in  system clock
//   reset_n     in  asynchronous active-low reset
//   msg_valid   in  message presented on msg
//   msg[23:0]   in  message word
//   msg_ready   out holding register empty
//   tx          out MIDI line, idle high
//   busy        out frame on the line or message pending
//   msg_done    out one-cycle pulse after the last stop bit of a message
//   msg_dropped out one-cycle pulse when an invalid-status message is consumed
// Build option: define MIDI_RUNNING_STATUS_EN to omit a status byte equal to
// the previously transmitted one.
// CLOCK_HZ/BAUD must be at least 2.
module midi_transmitter
    import midi_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 50_000_000,
    parameter int unsigned BAUD     = 31250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        msg_valid,
    input  logic [23:0] msg,
    output logic        msg_ready,
    output logic        tx,
    output logic        busy,
    output logic        msg_done,
    output logic        msg_dropped
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD;

    midi_state_e st_q, st_d, hold_entry;
    logic [23:0] hold_q, work_q, work_d;
    logic        hold_full_q, hold_full_d;
    logic        launch_q, launch_d;
    logic        msg_done_q, done_d;
    logic        msg_dropped_q, drop_d;
    logic        accept, hold_take, dispatch, hold_skip;
    logic [1:0]  hold_len, work_len;
    logic        byte_start, byte_done, uart_busy;
    logic [7:0]  byte_data;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]  rs_q;
`endif

    assign accept    = msg_valid && !hold_full_q;
    assign hold_len  = msg_len(hold_q[23:20]);
    assign work_len  = msg_len(work_q[23:20]);

    always_comb begin
        hold_skip = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        // rs_q is zero after reset, which no valid status byte matches
        hold_skip = (hold_q[23:16] == rs_q);
`endif
    end

    assign hold_entry = hold_skip ? StSendD1 : StSendStatus;

    always_comb begin
        st_d       = st_q;
        work_d     = work_q;
        launch_d   = 1'b0;
        hold_take  = 1'b0;
        dispatch   = 1'b0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        byte_start = 1'b0;
        byte_data  = 8'h00;
        unique case (st_q)
            StIdle: begin
                if (hold_full_q) begin
                    hold_take = 1'b1;
                    if (hold_len == 2'd0) begin
                        drop_d = 1'b1;
                    end else begin
                        dispatch = 1'b1;
                        work_d   = hold_q;
                        st_d     = hold_entry;
                        launch_d = 1'b1;
                    end
                end
            end
            default: begin
                if (launch_q) begin
                    // first byte of a message dispatched from idle
                    byte_start = 1'b1;
                    byte_data  = msg_byte(st_q, work_q);
                end else if (byte_done) begin
                    if (st_q == StSendStatus) begin
                        st_d       = StSendD1;
                        byte_start = 1'b1;
                        byte_data  = msg_byte(StSendD1, work_q);
                    end else if (st_q == StSendD1 && work_len == 2'd3) begin
                        st_d       = StSendD2;
                        byte_start = 1'b1;
                        byte_data  = msg_byte(StSendD2, work_q);
                    end else begin
                        done_d = 1'b1;
                        st_d   = StIdle;
                        // chain straight into a pending valid message so its
                        // start bit follows this stop bit
                        if (hold_full_q && hold_len != 2'd0) begin
                            hold_take  = 1'b1;
                            dispatch   = 1'b1;
                            work_d     = hold_q;
                            st_d       = hold_entry;
                            byte_start = 1'b1;
                            byte_data  = msg_byte(hold_entry, hold_q);
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (hold_take) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q          <= StIdle;
            hold_q        <= '0;
            work_q        <= '0;
            hold_full_q   <= 1'b0;
            launch_q      <= 1'b0;
            msg_done_q    <= 1'b0;
            msg_dropped_q <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            rs_q          <= 8'h00;
`endif
        end else begin
            st_q          <= st_d;
            work_q        <= work_d;
            hold_full_q   <= hold_full_d;
            launch_q      <= launch_d;
            msg_done_q    <= done_d;
            msg_dropped_q <= drop_d;
            if (accept) begin
                hold_q <= msg;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            if (dispatch) begin
                rs_q <= hold_q[23:16];
            end
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (byte_start),
        .data   (byte_data),
        .tx     (tx),
        .busy   (uart_busy),
        .done   (byte_done)
    );

    assign msg_ready   = !hold_full_q;
    assign busy        = uart_busy || (st_q != StIdle) || hold_full_q;
    assign msg_done    = msg_done_q;
    assign msg_dropped = msg_dropped_q;

endmodule

// File: doc/midi_transmitter.md
# midi_transmitter

Serial MIDI output port: accepts parsed 24-bit MIDI messages and serializes them as standard MIDI UART frames (8N1) on a single TX line. It takes the same message word format the MIDI receiver hands to the polyphonizer, so the synth can echo or forward note events to an external device. The block has a two-deep message buffer (one holding register plus the message in flight) and a byte serializer.

## Interface
- `CLOCK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 31250: serial bit rate. Derived constant `CLKS_PER_BIT = CLOCK_HZ/BAUD`, integer division, must be ≥ 2.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `msg_valid`  in  1  a message is presented on `msg`.
- `msg`  in  24  message word: [23:20] status nibble, [19:16] channel, [15:8] data1 (note), [7:0] data2 (velocity).
- `msg_ready`  out  1  holding register empty; a message is accepted on any edge where `msg_valid && msg_ready`.
- `tx`  out  1  MIDI serial line, idle high.
- `busy`  out  1  high while a frame is on the line or a message is pending.
- `msg_done`  out  1  one-cycle pulse after the last stop bit of each transmitted message.
- `msg_dropped`  out  1  one-cycle pulse when an accepted message has an invalid status.

## Operation
- Reset values: `tx`=1, `msg_ready`=1, `busy`=0, `msg_done`=0, `msg_dropped`=0. All internal state is cleared, including the running-status register.
- On reset assertion mid-frame, `tx` returns high immediately (asynchronously). The truncated frame is abandoned and the pending message is discarded.
- Byte encoding:
  - status byte = {msg[23:20], msg[19:16]}.
  - data bytes are forced to 7 bits: {1'b0, msg[14:8]} and {1'b0, msg[6:0]}.
- Message length by status nibble:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
  - 0xC, 0xD: 2 bytes; data2 is not sent.
  - 0x0–0x7, 0xF: invalid. The message is consumed, `msg_dropped` pulses, nothing is sent, and running status is unchanged.
- Message FSM states:
  - IDLE → SEND_STATUS when the holding register is full.
  - SEND_STATUS → SEND_D1.
  - SEND_D1 → SEND_D2 for 3-byte messages, or → IDLE for 2-byte messages.
  - SEND_D2 → IDLE.
  - Each SEND state lasts exactly one byte frame.
- The holding register is copied into the working register when leaving IDLE, which frees `msg_ready` on the following cycle. A new message can therefore be accepted while the current one is still shifting.
- If `msg_valid && msg_ready` occurs on the same edge as the holding-to-working transfer, the new message is captured into the holding register without loss.
- `msg` is sampled only on the accept edge; later changes are ignored.

## Timing
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts `CLKS_PER_BIT` cycles, so one frame is `10*CLKS_PER_BIT` cycles.
- Accept edge at cycle N with the block idle → `tx` falls at cycle N+2 (one cycle to load holding, one to load the shifter).
- Bytes within a message are back-to-back: no idle bits between frames.
- Back-to-back messages: the next start bit immediately follows the previous stop bit when the holding register is already full.
- `msg_done` is asserted in the cycle after the final stop bit's last clock. `busy` falls in that same cycle if nothing is pending.
- A 3-byte message at default parameters occupies 48000 cycles of line time.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - The last transmitted status byte is kept in a register.
  - If a valid message's status byte equals that register, SEND_STATUS is skipped and the FSM goes directly to SEND_D1.
  - The register is cleared by reset only.
  - 0xF nibbles never update it (they are dropped anyway).
- Macro undefined: the status byte is always sent and the register does not exist.

## Structure
- Package `midi_pkg`:
  - status nibble constants (NOTE_OFF=0x8, NOTE_ON=0x9, POLY_AT=0xA, CC=0xB, PROG=0xC, CHAN_AT=0xD, PITCH=0xE);
  - a `msg_len` function returning 0, 2 or 3;
  - the FSM state enum.
- Sub-module `uart_tx_byte`:
  - ports: `clock`, `reset_n`, `start`, `data[7:0]`, `tx`, `busy`, `done`;
  - contains the baud counter and 4-bit bit counter.
- The top level holds the message FSM, the holding/working registers and the running-status register.

## Test plan
All cases use `CLOCK_HZ=4000, BAUD=1000` (4 clocks/bit).
- Send 0x90_3C_64 from idle → `tx` falls 2 cycles after accept; line carries bytes 0x90, 0x3C, 0x64 LSB-first over 120 cycles; `msg_done` pulses once.
- Send 0x9A_FF_FF → bytes 0x9A, 0x7F, 0x7F (data bit 7 masked).
- Send 0xC2_05_77 → only 0x C2, 0x05 sent (80 cycles), then `msg_done`.
- Send 0x50_00_00 → `msg_dropped` pulses, `tx` stays high, `msg_ready` returns high after 1 cycle.
- Hold `msg_valid` high with two messages 0x90_40_7F then 0x80_40_00 → second accepted during the first's transmission; no idle gap; 6 bytes total. With `MIDI_RUNNING_STATUS_EN`, messages 0x90_40_7F then 0x90_41_7F produce 5 bytes.
- Assert `reset_n`=0 mid-data-bit → `tx`=1 immediately, `busy`=0, `msg_ready`=1; after release, a new message transmits correctly with its status byte sent.
